// File: rtl/sd_buf_pkg.sv
// Shared types and helpers for the SD sector buffer: FSM encoding, byte width
// and the word/lane to byte-address mapping.
package sd_buf_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } buf_state_e;

  // Byte address of a lane within a word; big-endian puts the lowest address in the MSB lane
  function automatic int byte_index(input int word_addr, input int lane,
                                    input logic little_endian, input int word_bytes);
    if (little_endian) begin
      return word_addr * word_bytes + lane;
    end else begin
      return word_addr * word_bytes + (word_bytes - 1 - lane);
    end
  endfunction

endpackage

// File: rtl/sd_word_lane.sv
// Combinational permutation between address-ordered bytes and host word lanes.
// The mapping is its own inverse, so one block serves both read and write paths.
module sd_word_lane
  import sd_buf_pkg::*;
#(
  parameter int WORD_BYTES = 2
) (
  input  logic                         little_endian,
  input  logic [BYTE_W*WORD_BYTES-1:0] din,
  input  logic [WORD_BYTES-1:0]        be_in,
  output logic [BYTE_W*WORD_BYTES-1:0] dout,
  output logic [WORD_BYTES-1:0]        be_out
);

  // Swap byte order for big-endian, pass straight through for little-endian
  always_comb begin
    dout   = '0;
    be_out = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (little_endian) begin
        dout[BYTE_W*i +: BYTE_W] = din[BYTE_W*i +: BYTE_W];
        be_out[i]                = be_in[i];
      end else begin
        dout[BYTE_W*i +: BYTE_W] = din[BYTE_W*(WORD_BYTES-1-i) +: BYTE_W];
        be_out[i]                = be_in[WORD_BYTES-1-i];
      end
    end
  end

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer between the SD byte stream and the host word port: byte fill,
// registered word reads, byte-enabled writes, dirty tracking and byte drain.
module sd_sector_buffer
  import sd_buf_pkg::*;
#(
  parameter int SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter int WORD_BYTES   = 2,
  parameter int ADDR_W       = (SECTOR_BYTES / WORD_BYTES > 1) ? $clog2(SECTOR_BYTES / WORD_BYTES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         abort,
  input  logic                         fill_start,
  input  logic                         fill_valid,
  input  logic [7:0]                   fill_byte,
  output logic                         fill_ready,
  input  logic                         drain_start,
  output logic                         drain_valid,
  output logic [7:0]                   drain_byte,
  input  logic                         drain_ready,
  input  logic                         little_endian,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [BYTE_W*WORD_BYTES-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [BYTE_W*WORD_BYTES-1:0] wr_data,
  input  logic [WORD_BYTES-1:0]        wr_be,
  output logic                         sector_valid,
  output logic                         dirty,
  output logic                         busy,
  output logic                         host_err
);

  localparam int CNT_W  = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SECTOR_BYTES - 1);

  logic [BYTE_W-1:0] mem [SECTOR_BYTES];

  buf_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sector_valid_q, sector_valid_d;
  logic              dirty_q, dirty_d;
  logic              drain_valid_q, drain_valid_d;
  logic [7:0]        drain_byte_q, drain_byte_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              host_err_q, host_err_d;

  logic              in_ready;
  logic              fill_acc, fill_last, drain_acc, drain_last;
  logic [CNT_W-1:0]  cnt_inc;
  logic [WORD_W-1:0] rd_bytes, rd_lanes, wr_bytes;
  logic [WORD_BYTES-1:0] rd_mask, wr_be_bytes;

  assign in_ready   = (state_q == ST_READY);
  assign fill_acc   = fill_valid && fill_ready;
  assign fill_last  = fill_acc && (cnt_q == LAST_CNT);
  assign drain_acc  = (state_q == ST_DRAIN) && drain_valid_q && drain_ready;
  assign drain_last = drain_acc && (cnt_q == LAST_CNT);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Gather the addressed word's bytes in ascending address order
  always_comb begin
    rd_bytes = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      rd_bytes[BYTE_W*k +: BYTE_W] = mem[CNT_W'(byte_index(int'(rd_addr), k, 1'b1, WORD_BYTES))];
    end
  end

  // Lane mask doubles as the read gate so non-READY reads return zero
  sd_word_lane #(.WORD_BYTES(WORD_BYTES)) u_rd_lane (
    .little_endian (little_endian),
    .din           (rd_bytes),
    .be_in         ({WORD_BYTES{rd_en && in_ready}}),
    .dout          (rd_lanes),
    .be_out        (rd_mask)
  );

  sd_word_lane #(.WORD_BYTES(WORD_BYTES)) u_wr_lane (
    .little_endian (little_endian),
    .din           (wr_data),
    .be_in         (wr_be),
    .dout          (wr_bytes),
    .be_out        (wr_be_bytes)
  );

  // Host read response and rejection pulse
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (rd_mask[i]) begin
        rd_data_d[BYTE_W*i +: BYTE_W] = rd_lanes[BYTE_W*i +: BYTE_W];
      end else begin
        rd_data_d[BYTE_W*i +: BYTE_W] = 8'h00;
      end
    end
    rd_valid_d = rd_en;
    host_err_d = (rd_en || wr_en) && !in_ready;
  end

  // Sector storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      mem[cnt_q] <= fill_byte;
    end
    if (wr_en && in_ready) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (wr_be_bytes[k]) begin
          mem[CNT_W'(byte_index(int'(wr_addr), k, 1'b1, WORD_BYTES))] <= wr_bytes[BYTE_W*k +: BYTE_W];
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: abort beats fill_start beats drain_start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (fill_start) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FILL:  if (fill_last)   state_d = ST_READY; else state_d = ST_FILL;
        ST_READY: if (drain_start) state_d = ST_DRAIN; else state_d = ST_READY;
        ST_DRAIN: if (drain_last)  state_d = ST_READY; else state_d = ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from state
  always_comb begin
    fill_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_FILL:  begin fill_ready = 1'b1; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      default:  begin fill_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Counter, status flags and drain byte
  always_comb begin
    cnt_d          = cnt_q;
    sector_valid_d = sector_valid_q;
    dirty_d        = dirty_q;
    drain_valid_d  = drain_valid_q;
    drain_byte_d   = drain_byte_q;
    if (abort) begin
      cnt_d          = '0;
      sector_valid_d = 1'b0;
      dirty_d        = 1'b0;
      drain_valid_d  = 1'b0;
    end else if (fill_start) begin
      cnt_d          = '0;
      sector_valid_d = 1'b0;
      drain_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_last) begin
            cnt_d          = '0;
            sector_valid_d = 1'b1;
            dirty_d        = 1'b0;
          end else if (fill_acc) begin
            cnt_d = cnt_inc;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_READY: begin
          if (drain_start) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q;
          end
          if (wr_en) begin
            dirty_d = 1'b1;
          end else begin
            dirty_d = dirty_q;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle loads byte 0; afterwards each handshake preloads the next
          if (!drain_valid_q) begin
            drain_valid_d = 1'b1;
            drain_byte_d  = mem[cnt_q];
          end else if (drain_last) begin
            drain_valid_d = 1'b0;
            cnt_d         = '0;
            dirty_d       = 1'b0;
          end else if (drain_acc) begin
            cnt_d        = cnt_inc;
            drain_byte_d = mem[cnt_inc];
          end else begin
            drain_byte_d = drain_byte_q;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Registered datapath and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      sector_valid_q <= 1'b0;
      dirty_q        <= 1'b0;
      drain_valid_q  <= 1'b0;
      drain_byte_q   <= 8'h00;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      host_err_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      sector_valid_q <= sector_valid_d;
      dirty_q        <= dirty_d;
      drain_valid_q  <= drain_valid_d;
      drain_byte_q   <= drain_byte_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      host_err_q     <= host_err_d;
    end
  end

  assign sector_valid = sector_valid_q;
  assign dirty        = dirty_q;
  assign drain_valid  = drain_valid_q;
  assign drain_byte   = drain_byte_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign host_err     = host_err_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Randomised scoreboard bench for sd_sector_buffer against a byte-array sector model.
module tb_sd_sector_buffer;

  localparam int SB = 512;
  localparam int WB = 2;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, fill_start, fill_valid, fill_ready;
  logic [7:0]  fill_byte, drain_byte;
  logic        drain_start, drain_valid, drain_ready, little_endian;
  logic        rd_en, rd_valid, wr_en, sector_valid, dirty, busy, host_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0] rd_data, wr_data;
  logic [1:0]  wr_be;

  sd_sector_buffer #(.SECTOR_BYTES(SB), .WORD_BYTES(WB)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .fill_start(fill_start),
    .fill_valid(fill_valid), .fill_byte(fill_byte), .fill_ready(fill_ready),
    .drain_start(drain_start), .drain_valid(drain_valid), .drain_byte(drain_byte),
    .drain_ready(drain_ready), .little_endian(little_endian), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .sector_valid(sector_valid),
    .dirty(dirty), .busy(busy), .host_err(host_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the sector as plain bytes plus three status flags
  logic [7:0] mm [SB];
  bit m_ready = 1'b0, m_sv = 1'b0, m_dirty = 1'b0;

  typedef struct { logic [15:0] data; logic err; } rd_exp_t;
  rd_exp_t    rdq [$];
  logic [7:0] drq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mword(input int a, input bit le);
    if (le) return {mm[2*a+1], mm[2*a]};
    else    return {mm[2*a], mm[2*a+1]};
  endfunction

  task automatic mwrite(input int a, input logic [15:0] d, input logic [1:0] be, input bit le);
    for (int i = 0; i < 2; i++)
      if (be[i]) mm[le ? 2*a+i : 2*a+1-i] = d[8*i +: 8];
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or drain byte
  initial begin : monitor
    rd_exp_t    e;
    logic [7:0] eb;
    bit         hold_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (rdq.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no read");
        end else begin
          e = rdq.pop_front();
          chk("rd_data", {16'h0, rd_data}, {16'h0, e.data});
          chk("rd_host_err", {31'h0, host_err}, {31'h0, e.err});
        end
      end
      if (drain_valid && hold_prev) chk("drain_hold", {24'h0, drain_byte}, {24'h0, byte_prev});
      if (drain_valid && drain_ready) begin
        if (drq.size() == 0) begin
          n_total++;
          $display("FAIL drain_unexpected: got byte 0x%0h expected none", drain_byte);
        end else begin
          eb = drq.pop_front();
          chk("drain_byte", {24'h0, drain_byte}, {24'h0, eb});
        end
      end
      hold_prev = drain_valid && !drain_ready;
      byte_prev = drain_byte;
    end
  end

  task automatic fill(input bit rnd, input int n);
    int k = 0, guard = 0;
    bit acc;
    logic [7:0] b;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    m_ready = 1'b0; m_sv = 1'b0;
    chk("fill_ready_entry", {31'h0, fill_ready}, 32'd1);
    chk("fill_sv_cleared", {31'h0, sector_valid}, 32'd0);
    while (k < n && guard < 8*SB) begin
      b = rnd ? 8'($urandom) : 8'(k);
      fill_valid = ($urandom_range(0, 3) != 0);
      fill_byte  = b;
      acc = fill_valid && fill_ready;
      if (acc && k == SB-1) chk("sv_before_last", {31'h0, sector_valid}, 32'd0);
      tick();
      guard++;
      if (acc) begin mm[k] = b; k++; end
    end
    fill_valid = 1'b0;
    fill_byte  = 8'h00;
    chk("fill_count", k, n);
    if (n == SB) begin
      chk("sv_after_last", {31'h0, sector_valid}, 32'd1);
      chk("fill_busy_done", {31'h0, busy}, 32'd0);
      chk("fill_dirty_done", {31'h0, dirty}, 32'd0);
      m_ready = 1'b1; m_sv = 1'b1; m_dirty = 1'b0;
    end
  endtask

  task automatic host(input bit rd, input bit wr, input int ra, input int wa,
                      input logic [15:0] wd, input logic [1:0] be, input bit le);
    rd_en = rd; wr_en = wr; rd_addr = 8'(ra); wr_addr = 8'(wa);
    wr_data = wd; wr_be = be; little_endian = le;
    if (rd) rdq.push_back('{m_ready ? mword(ra, le) : 16'h0000, !m_ready});
    if (wr && m_ready) begin mwrite(wa, wd, be, le); m_dirty = 1'b1; end
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    if (wr && !rd) chk("wr_host_err", {31'h0, host_err}, {31'h0, !m_ready});
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_ready = 1'b0; m_sv = 1'b0; m_dirty = 1'b0;
    chk("abort_sv", {31'h0, sector_valid}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
  endtask

  task automatic drain(input int abort_at);
    int cnt = 0, guard = 0;
    drain_start = 1'b1;
    for (int k = 0; k < SB; k++) drq.push_back(mm[k]);
    tick();
    drain_start = 1'b0;
    chk("drain_busy", {31'h0, busy}, 32'd1);
    while (busy && guard < 8*SB) begin
      drain_ready = ~drain_ready;
      @(negedge clk);
      if (drain_valid && drain_ready) cnt++;
      tick();
      guard++;
      if (abort_at > 0 && cnt == abort_at) break;
    end
    drain_ready = 1'b0;
    if (abort_at > 0) begin
      chk("abort_count", cnt, abort_at);
      do_abort();
      drq.delete();
      chk("abort_drain_valid", {31'h0, drain_valid}, 32'd0);
      chk("abort_dirty", {31'h0, dirty}, 32'd0);
    end else begin
      m_dirty = 1'b0;
      chk("drain_count", cnt, SB);
      chk("drain_left", drq.size(), 32'd0);
      chk("drain_dirty", {31'h0, dirty}, 32'd0);
      chk("drain_busy_done", {31'h0, busy}, 32'd0);
      chk("drain_sv", {31'h0, sector_valid}, 32'd1);
      chk("drain_valid_done", {31'h0, drain_valid}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fill_ready"}, {31'h0, fill_ready}, 32'd0);
    chk({tag, "_drain_valid"}, {31'h0, drain_valid}, 32'd0);
    chk({tag, "_rd_valid"}, {31'h0, rd_valid}, 32'd0);
    chk({tag, "_sector_valid"}, {31'h0, sector_valid}, 32'd0);
    chk({tag, "_dirty"}, {31'h0, dirty}, 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
    chk({tag, "_host_err"}, {31'h0, host_err}, 32'd0);
    chk({tag, "_drain_byte"}, {24'h0, drain_byte}, 32'd0);
    chk({tag, "_rd_data"}, {16'h0, rd_data}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ra, op;
    rst_n = 1'b0; abort = 1'b0; fill_start = 1'b0; fill_valid = 1'b0; fill_byte = 8'h00;
    drain_start = 1'b0; drain_ready = 1'b0; little_endian = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = 16'h0; wr_be = 2'b00;
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("idle_drain_ignored", {31'h0, busy}, 32'd0);

    fill(1'b0, SB);
    host(1'b1, 1'b0, 3, 0, 16'h0, 2'b00, 1'b0);
    host(1'b1, 1'b0, 3, 0, 16'h0, 2'b00, 1'b1);
    host(1'b0, 1'b1, 0, 5, 16'hABCD, 2'b01, 1'b0);
    host(1'b1, 1'b0, 5, 0, 16'h0, 2'b00, 1'b0);
    chk("dirty_after_write", {31'h0, dirty}, 32'd1);

    // Mixed random traffic, including same-address read/write collisions
    repeat (150) begin
      ra = $urandom_range(0, 255);
      op = $urandom_range(0, 3);
      case (op)
        0: host(1'b1, 1'b0, ra, 0, 16'h0, 2'b00, 1'($urandom));
        1: if (ra == 5) host(1'b1, 1'b0, ra, 0, 16'h0, 2'b00, 1'b0);
           else host(1'b0, 1'b1, 0, ra, 16'($urandom), 2'($urandom), 1'($urandom));
        2: if (ra == 5) host(1'b1, 1'b0, ra, 0, 16'h0, 2'b00, 1'b1);
           else host(1'b1, 1'b1, ra, ra, 16'($urandom), 2'($urandom), 1'($urandom));
        default: host(1'b1, 1'b1, ra, $urandom_range(0, 255) | 1, 16'($urandom), 2'b11, 1'($urandom));
      endcase
    end
    chk("dirty_model", {31'h0, dirty}, {31'h0, m_dirty});
    drain(0);
    host(1'b1, 1'b0, 200, 0, 16'h0, 2'b00, 1'b1);

    // Host access while filling is rejected
    fill(1'b0, 50);
    host(1'b1, 1'b0, 3, 0, 16'h0, 2'b00, 1'b0);
    host(1'b0, 1'b1, 0, 1, 16'h1234, 2'b11, 1'b0);
    do_abort();

    fill(1'b1, SB);
    fill_valid = 1'b1;
    fill_byte  = 8'h55;
    repeat (3) tick();
    fill_valid = 1'b0;
    host(1'b1, 1'b0, 0, 0, 16'h0, 2'b00, 1'b0);
    host(1'b1, 1'b0, 255, 0, 16'h0, 2'b00, 1'b1);
    chk("sv_stays_ready", {31'h0, sector_valid}, 32'd1);

    // Asynchronous reset in the middle of a fill
    fill(1'b1, 100);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b0; m_sv = 1'b0; m_dirty = 1'b0;
    tick();
    host(1'b1, 1'b0, 7, 0, 16'h0, 2'b00, 1'b0);

    fill(1'b1, SB);
    drain(200);
    host(1'b1, 1'b0, 9, 0, 16'h0, 2'b00, 1'b0);

    // fill_start outranks drain_start
    fill(1'b0, SB);
    fill_start = 1'b1;
    drain_start = 1'b1;
    tick();
    fill_start = 1'b0;
    drain_start = 1'b0;
    m_ready = 1'b0; m_sv = 1'b0;
    chk("prio_fill_ready", {31'h0, fill_ready}, 32'd1);
    chk("prio_sv", {31'h0, sector_valid}, 32'd0);
    chk("prio_drain_valid", {31'h0, drain_valid}, 32'd0);
    do_abort();

    repeat (3) tick();
    chk("rd_queue_empty", rdq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
